// File: rtl/jk_drv_pkg.sv
// Shared types and the JK excitation function for jk_excitation_driver.
// Optional build macro: JK_TOGGLE_FORM_EN selects toggle-form excitation
// (J=K=q^t) instead of the minimal form that never drives JK=11.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Per-bit excitation: returns {j, k} that moves a JK flop from q to t.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
`ifdef JK_TOGGLE_FORM_EN
        // Don't-cares resolved to toggle: a changing bit gets 11, a steady bit 00.
        return {q ^ t, q ^ t};
`else
        // Minimal form: set on 0->1, reset on 1->0, hold otherwise.
        return {~q & t, q & ~t};
`endif
    endfunction

endpackage

// File: rtl/jk_excitation_driver_fifo.sv
// Target-word FIFO for jk_excitation_driver: W x DEPTH, extra pointer bit
// distinguishes full from empty. Push is refused while full, even when a pop
// happens on the same edge.
module jk_drv_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push / pop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) wr_ptr_d = wr_ptr_q + PTR_INC;
        if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_INC;
    end

    // Pointer registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values, independent of block order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are don't-care until pointers mark them valid.
    always_ff @(posedge clk) begin
        // NOTE: the memory is deliberately not reset; empty pointers make stale data unobservable and a resettable array cannot map to RAM.
        if (push && !full) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: pops target words, drives J/K excitation for one edge
// of an external JK bank, then checks the fed-back Q against the target.
// Optional build macro: JK_TOGGLE_FORM_EN (toggle-form excitation, see pkg).
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             hold,
    input  logic [W-1:0]     q_fb,
    output logic [W-1:0]     j,
    output logic [W-1:0]     k,
    output logic             apply,
    output logic [W-1:0]     q_model,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clear_err
);

    state_t             state_q, state_d;
    logic [W-1:0]       j_q, j_d, k_q, k_d;
    logic               apply_q, apply_d;
    logic [W-1:0]       q_model_q, q_model_d;
    logic [W-1:0]       tgt_q, tgt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [W-1:0]       fifo_head;

    jk_drv_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .din   (in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign j         = j_q;
    assign k         = k_q;
    assign apply     = apply_q;
    assign q_model   = q_model_q;
    assign err       = err_q;
    assign err_count = err_count_q;

    // Next-state, excitation and error logic for IDLE -> APPLY -> CHECK.
    always_comb begin
        state_d     = state_q;
        j_d         = '0;
        k_d         = '0;
        apply_d     = 1'b0;
        q_model_d   = q_model_q;
        tgt_d       = tgt_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && !hold) begin
                    fifo_pop = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        {j_d[i], k_d[i]} = jk_excite(q_model_q[i], fifo_head[i]);
                    end
                    apply_d = 1'b1;
                    tgt_d   = fifo_head;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                // The bank samples j/k on this edge; excitation drops to zero.
                q_model_d = tgt_q;
                state_d   = CHECK;
            end
            CHECK: begin
                if (q_fb != q_model_q) begin
                    err_d = 1'b1;
                    if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a simultaneous mismatch.
        if (clear_err) begin
            err_d       = 1'b0;
            err_count_d = '0;
        end
    end

    // State and output registers; reset removes any excitation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            j_q         <= '0;
            k_q         <= '0;
            apply_q     <= 1'b0;
            q_model_q   <= '0;
            tgt_q       <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            k_q         <= k_d;
            apply_q     <= apply_d;
            q_model_q   <= q_model_d;
            tgt_q       <= tgt_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench for jk_excitation_driver (W=4, DEPTH=4, CNT_W=8).
// Honours JK_TOGGLE_FORM_EN for the expected excitation encoding.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       hold = 1'b0;
    logic [3:0] q_fb;
    logic [3:0] j, k;
    logic       apply;
    logic [3:0] q_model;
    logic       busy;
    logic       err;
    logic [7:0] err_count;
    logic       clear_err = 1'b0;

    // External JK bank model and a bit0 stuck-at-0 fault injector.
    logic [3:0] bank;
    logic       stuck = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: last applied target, expected error count, pending words.
    logic [3:0] mq = '0;
    int         exp_cnt = 0;
    logic [3:0] pend[$];
    logic [3:0] last_j, last_k;

    jk_excitation_driver #(.W(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hold      (hold),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .apply     (apply),
        .q_model   (q_model),
        .busy      (busy),
        .err       (err),
        .err_count (err_count),
        .clear_err (clear_err)
    );

    always #5 clk = ~clk;

    // JK characteristic equation: Q+ = J&~Q | ~K&Q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bank <= '0;
        else     bank <= (j & ~bank) | (~k & bank);
    end

    assign q_fb = stuck ? (bank & 4'b1110) : bank;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("push_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        pend.push_back(w);
    endtask

    // Waits for the apply strobe of target t and checks the full apply/check round.
    task automatic expect_apply(input bit do_clear, output int waited);
        logic [3:0] t, je, ke;
        t = pend.pop_front();
        waited = 0;
        while (!apply && waited < 20) begin
            tick();
            waited++;
        end
        check("apply_seen", apply, 1);
`ifdef JK_TOGGLE_FORM_EN
        je = mq ^ t;
        ke = mq ^ t;
`else
        je = ~mq & t;
        ke = mq & ~t;
`endif
        check("j_excite", j, je);
        check("k_excite", k, ke);
        last_j = j;
        last_k = k;
        tick();
        in_valid = 1'b0;
        check("apply_drop", apply, 0);
        check("j_zero", j, 0);
        check("k_zero", k, 0);
        check("q_model", q_model, t);
        clear_err = do_clear;
        tick();
        clear_err = 1'b0;
        if (do_clear)                 exp_cnt = 0;
        else if (stuck && t[0])       exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        check("err", err, (exp_cnt != 0));
        check("err_count", err_count, exp_cnt);
        mq = t;
    endtask

    initial begin
        int         w;
        logic [3:0] w5;
        #12;
        // Reset state.
        check("rst_j", j, 0);
        check("rst_k", k, 0);
        check("rst_apply", apply, 0);
        check("rst_q_model", q_model, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single target: popped on the edge after the push.
        push_word(4'b1010);
        check("busy_after_push", busy, 1);
        check("no_apply_yet", apply, 0);
        expect_apply(1'b0, w);
        check("latency", w, 1);

        // Directed sequence through the bank model.
        hold = 1'b1;
        push_word(4'b0110);
        push_word(4'b1111);
        push_word(4'b0000);
        hold = 1'b0;
        expect_apply(1'b0, w);
`ifdef JK_TOGGLE_FORM_EN
        check("step_j_1010_0110", last_j, 4'b1100);
        check("step_k_1010_0110", last_k, 4'b1100);
`else
        check("step_j_1010_0110", last_j, 4'b0100);
        check("step_k_1010_0110", last_k, 4'b1000);
`endif
        expect_apply(1'b0, w);
        expect_apply(1'b0, w);
        check("seq_final_q_model", q_model, 4'b0000);
        check("seq_bank", bank, 4'b0000);

        // Full FIFO under hold: fifth word refused until a slot frees.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_word(4'($urandom_range(0, 15)));
        check("full_in_ready", in_ready, 0);
        w5 = 4'($urandom_range(0, 15));
        in_valid = 1'b1;
        in_data  = w5;
        tick();
        tick();
        check("full_still", in_ready, 0);
        check("held_no_apply", apply, 0);
        check("held_busy", busy, 1);
        hold = 1'b0;
        tick();
        check("slot_free", in_ready, 1);
        expect_apply(1'b0, w);
        pend.push_back(w5);
        for (int i = 0; i < 4; i++) expect_apply(1'b0, w);
        check("drained_busy", busy, 0);

        // Stuck bit0: mismatch, then clear coinciding with another mismatch.
        stuck = 1'b1;
        push_word(4'b0001);
        expect_apply(1'b0, w);
        check("stuck_err", err, 1);
        check("stuck_cnt", err_count, 1);
        push_word(4'b0011);
        expect_apply(1'b1, w);
        check("clear_err", err, 0);
        check("clear_cnt", err_count, 0);

        // Counter saturation.
        for (int i = 0; i < 258; i++) begin
            push_word({3'($urandom_range(0, 7)), 1'b1});
            expect_apply(1'b0, w);
        end
        check("sat_cnt", err_count, 255);
        stuck = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        exp_cnt = 0;
        check("sat_cleared", err_count, 0);

        // Reset during APPLY with two words queued.
        hold = 1'b1;
        push_word(4'b0101);
        push_word(4'b1100);
        push_word(4'b0011);
        hold = 1'b0;
        tick();
        check("pre_rst_apply", apply, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_j", j, 0);
        check("mid_rst_k", k, 0);
        check("mid_rst_apply", apply, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        pend.delete();
        mq = '0;
        exp_cnt = 0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_apply", apply, 0);
        check("post_rst_q_model", q_model, 0);

        // Randomized bursts against the reference model.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 4);
            hold = 1'b1;
            for (int i = 0; i < n; i++) push_word(4'($urandom_range(0, 15)));
            hold = 1'b0;
            for (int i = 0; i < n; i++) expect_apply(1'b0, w);
            check("rand_bank", bank, mq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
